// File: rtl/trng_pkg.sv
// Shared constants and types for the TRNG raw-bit collector.
// Pure declarations; no logic, no latency.
package trng_pkg;
    localparam int RAW_SYNC_DEFAULT   = 2;
    localparam int RCT_CUTOFF_DEFAULT = 16;
    localparam int FIFO_DEPTH_DEFAULT = 4;
    localparam int BYTE_W             = 8;

    typedef enum logic [1:0] {
        VN_00 = 2'b00,
        VN_01 = 2'b01,
        VN_10 = 2'b10,
        VN_11 = 2'b11
    } vn_pair_t;
endpackage

// File: rtl/trng_vn_collector_if.sv
// Byte readout port: collector drives valid/data/level, consumer drives ready.
// Pop happens on valid & ready; data holds while valid & ~ready.
interface trng_vn_collector_if #(
    parameter int FIFO_DEPTH = trng_pkg::FIFO_DEPTH_DEFAULT
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                       rd_valid;
    logic                       rd_ready;
    logic [trng_pkg::BYTE_W-1:0] rd_data;
    logic [LVL_W-1:0]           fifo_level;

    modport master (output rd_valid, output rd_data, output fifo_level, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input fifo_level, output rd_ready);
endinterface

// File: rtl/trng_byte_fifo.sv
// Small byte FIFO, push visible at head one cycle later (no fall-through).
// Push on full is refused unless a pop happens in the same cycle.
module trng_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [WIDTH-1:0]         head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             push_ok;
    logic             pop_ok;

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (level_o == (AW+1)'(DEPTH));
    assign empty_o = (level_o == '0);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_i);
    // Empty FIFO presents zero so stale entries never leak out.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/trng_vn_collector.sv
// RO raw bit -> synchroniser -> von Neumann debias -> byte packer -> FIFO, with RCT health gate.
// Last debiased bit reaches rd_valid in 2 cycles; bytes arriving at a full FIFO are dropped and flagged.
module trng_vn_collector
    import trng_pkg::*;
#(
    parameter int SYNC_STAGES = RAW_SYNC_DEFAULT,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEFAULT,
    parameter int RCT_CUTOFF  = RCT_CUTOFF_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        raw_bit_i,
    input  logic                        sample_en_i,
    input  logic                        bypass_vn_i,
    input  logic                        alarm_clr_i,
    trng_vn_collector_if.master         rd,
    output logic                        overflow_o,
    output logic                        health_alarm_o
);
    localparam int CNT_W = $clog2(BYTE_W);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   sample;

    logic             alarm_q, alarm_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       rct_cnt_q, rct_cnt_d, rct_nxt;
    logic             prev_q, prev_d;
    logic             phase_q, phase_d, phase_eff;
    logic             a_q, a_d;
    logic             bypass_q;
    logic [BYTE_W-1:0] pack_q, pack_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             byte_vld_q, byte_vld_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic             emit, ebit, cutoff;

    logic             fifo_full, fifo_empty, pop;
    logic [BYTE_W-1:0] fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    assign s      = sync_q[SYNC_STAGES-1];
    assign sample = sample_en_i & ~alarm_q;
    assign pop    = ~fifo_empty & rd.rd_ready;

    always_comb begin
        alarm_d    = alarm_q;
        ovf_d      = ovf_q;
        rct_cnt_d  = rct_cnt_q;
        prev_d     = prev_q;
        a_d        = a_q;
        pack_d     = pack_q;
        cnt_d      = cnt_q;
        byte_vld_d = 1'b0;
        byte_d     = byte_q;
        emit       = 1'b0;
        ebit       = 1'b0;
        cutoff     = 1'b0;
        // A change of bypass mode restarts pairing so a stale half-pair is never compared.
        phase_eff  = (bypass_vn_i != bypass_q) ? 1'b0 : phase_q;
        phase_d    = phase_eff;
        rct_nxt    = (s == prev_q) ? ((rct_cnt_q == 8'hFF) ? 8'hFF : rct_cnt_q + 8'd1) : 8'd1;

        if (sample) begin
            prev_d    = s;
            rct_cnt_d = rct_nxt;
            cutoff    = (rct_nxt == 8'(RCT_CUTOFF));
            if (bypass_vn_i) begin
                emit    = 1'b1;
                ebit    = s;
                phase_d = 1'b0;
            end else if (!phase_eff) begin
                a_d     = s;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                case (vn_pair_t'({a_q, s}))
                    VN_01:   begin emit = 1'b1; ebit = 1'b0; end
                    VN_10:   begin emit = 1'b1; ebit = 1'b1; end
                    default: ;
                endcase
            end
        end

        if (cutoff) begin
            alarm_d = 1'b1;
            phase_d = 1'b0;
            cnt_d   = '0;
        end else if (emit) begin
            pack_d = {ebit, pack_q[BYTE_W-1:1]};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BYTE_W - 1)) begin
                byte_vld_d = 1'b1;
                byte_d     = pack_d;
            end
        end

        if (byte_vld_q && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end

        if (alarm_clr_i) begin
            alarm_d   = 1'b0;
            ovf_d     = 1'b0;
            rct_cnt_d = '0;
            prev_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            alarm_q    <= 1'b0;
            ovf_q      <= 1'b0;
            rct_cnt_q  <= '0;
            prev_q     <= 1'b0;
            phase_q    <= 1'b0;
            a_q        <= 1'b0;
            bypass_q   <= 1'b0;
            pack_q     <= '0;
            cnt_q      <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], raw_bit_i};
            alarm_q    <= alarm_d;
            ovf_q      <= ovf_d;
            rct_cnt_q  <= rct_cnt_d;
            prev_q     <= prev_d;
            phase_q    <= phase_d;
            a_q        <= a_d;
            bypass_q   <= bypass_vn_i;
            pack_q     <= pack_d;
            cnt_q      <= cnt_d;
            byte_vld_q <= byte_vld_d;
            byte_q     <= byte_d;
        end
    end

    trng_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (byte_vld_q),
        .push_dat_i (byte_q),
        .pop_i      (pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level),
        .head_o     (fifo_head)
    );

    assign rd.rd_valid    = ~fifo_empty;
    assign rd.rd_data     = fifo_head;
    assign rd.fifo_level  = fifo_level;
    assign overflow_o     = ovf_q;
    assign health_alarm_o = alarm_q;
endmodule
